spram_wb_bridge: RTL
====================

SPRAM_WB_BRIDGE -- requirements
Module: spram_wb_bridge

Interface
REQ-001 SHALL have parameter SIZE, default 'h80: RAM size in bytes, power of two, >= 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(SIZE)-2: RAM word-address width.
REQ-003 SHALL have parameter INIT_ZERO, default 1: 1 = zero-fill RAM after reset, 0 = no fill.
REQ-004 SHALL have ports:
  clk  input  1  clock, all logic on rising edge
  rst  input  1  reset, asynchronous, active-high
  wb_cyc_i  input  1  Wishbone cycle
  wb_stb_i  input  1  Wishbone strobe
  wb_we_i  input  1  1 = write, 0 = read
  wb_adr_i  input  32  byte address
  wb_sel_i  input  4  byte lane selects
  wb_dat_i  input  32  write data
  wb_dat_o  output  32  read data
  wb_ack_o  output  1  transfer acknowledge
  wb_err_o  output  1  transfer error
  wb_stall_o  output  1  pipeline stall
  ram_addr  output  ADDR_WIDTH  RAM word address
  ram_ce  output  1  RAM chip enable
  ram_we  output  4  RAM byte write enables
  ram_d  output  32  RAM write data
  ram_q  input  32  RAM read data, valid one clk after ram_ce
REQ-005 SHALL drive all ram_* outputs and wb_ack_o, wb_err_o, wb_stall_o from registers.

Function
REQ-006 SHALL implement Wishbone B4 pipelined slave; a request is accepted on an edge where wb_cyc_i & wb_stb_i & !wb_stall_o.
REQ-007 SHALL have states INIT and RUN; INIT entered on reset when INIT_ZERO=1, otherwise RUN.
REQ-008 INIT: wb_stall_o=1; each cycle ram_ce=1, ram_we=4'hF, ram_d=0, ram_addr=fill counter from 0 up by 1.
REQ-009 INIT -> RUN after the cycle with ram_addr=SIZE/4-1; fill takes exactly SIZE/4 cycles; no wrap.
REQ-010 RUN: wb_stall_o=0; one request accepted per cycle, back-to-back, in order.
REQ-011 Decode: word address = wb_adr_i[ADDR_WIDTH+1:2]; wb_adr_i[1:0] ignored; out of range if any wb_adr_i[31:ADDR_WIDTH+2] set.
REQ-012 In-range request accepted at edge E0: cycle after E0 ram_ce=1, ram_addr=word address, ram_we=wb_we_i ? wb_sel_i : 4'h0, ram_d=wb_dat_i.
REQ-013 wb_ack_o SHALL be 1 for exactly one cycle, the cycle after E1 (= E0+1).
REQ-014 Read: wb_dat_o = ram_q while wb_ack_o=1.
REQ-015 wb_dat_o SHALL be 0 whenever wb_ack_o=0.
REQ-016 Write with wb_sel_i=0: ram_ce=1, ram_we=0; acked normally; RAM unchanged.
REQ-017 Out-of-range request: ram_ce stays 0; wb_err_o=1 for one cycle in the same slot ack would occupy; wb_ack_o=0.
REQ-018 wb_ack_o and wb_err_o SHALL never both be 1.
REQ-019 Idle RUN cycles: ram_ce=0, ram_we=0.
REQ-020 Abort, wb_cyc_i=0 at an edge: every stage of the request pipeline is invalidated.
REQ-021 Abort: an invalidated request issues no RAM access if not yet driven and produces no ack/err.
REQ-022 Abort: a RAM access already driven completes, but its ack/err is suppressed.
REQ-023 Requests arriving during INIT are not accepted (stall) and SHALL NOT corrupt the fill.

Reset
REQ-024 rst=1 SHALL immediately force wb_ack_o=0, wb_err_o=0, ram_ce=0, ram_we=0, ram_addr=0, ram_d=0, wb_dat_o=0.
REQ-025 rst=1 SHALL immediately clear the fill counter and the pipeline valids.
REQ-026 rst=1 SHALL force wb_stall_o=INIT_ZERO.
REQ-027 Reset asserted mid-INIT or mid-transfer SHALL discard all in-flight requests and restart per REQ-007 on release.

Verification
REQ-028 SIZE='h80, INIT_ZERO=1, release reset -> stall=1 for 32 cycles, ram_addr 0..31 with we=4'hF, d=0, then stall=0.
REQ-029 Write 0x12345678 to 0x10 sel=4'hF, then read 0x10 -> ram_we=4'hF at addr 4; ack two cycles after each stb; read data 0x12345678.
REQ-030 Write 0xAABBCCDD to 0x10 sel=4'b0010, then read 0x10 -> read data 0x1234CC78.
REQ-031 Back-to-back reads of 0x00, 0x04, 0x08 (words 0xA, 0xB, 0xC) -> three consecutive ack cycles, data 0xA, 0xB, 0xC in order.
REQ-032 Read of 0x80, then read of 0x04 -> err on the first slot with ram_ce=0, ack on the second; never both.
REQ-033 Drop wb_cyc_i one cycle after a write to 0x20 is accepted -> write reaches RAM; no ack.
REQ-034 Assert rst during INIT at ram_addr=10 -> outputs zero at once; fill restarts at 0 after release.

Source files
------------

// File: rtl/spram_wb_bridge.sv
// Wishbone B4 pipelined slave bridging to a single-port byte-writable RAM.
// Optionally zero-fills the RAM after reset before accepting requests.
`timescale 1ns/1ps
module spram_wb_bridge #(
  parameter int SIZE       = 'h80,
  parameter int ADDR_WIDTH = $clog2(SIZE) - 2,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_d,
  input  logic [31:0]           ram_q
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t              RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH:0] FILL_ONE  = 1;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_fill, w_fill_nxt;
  logic                  r_stall, w_stall_nxt;
  logic                  r_ram_ce, w_ram_ce_nxt;
  logic [3:0]            r_ram_we, w_ram_we_nxt;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [31:0]           r_ram_d, w_ram_d_nxt;
  logic                  r_s1_vld, w_s1_vld_nxt;
  logic                  r_s1_err, w_s1_err_nxt;
  logic                  r_s1_rd, w_s1_rd_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_ack_rd, w_ack_rd_nxt;

  logic w_accept;
  logic w_oor;
  logic w_unused_adr;

  assign w_accept     = wb_cyc_i & wb_stb_i & ~r_stall;
  assign w_oor        = |wb_adr_i[31:ADDR_WIDTH+2];
  assign w_unused_adr = ^wb_adr_i[1:0];

  // Dropping wb_cyc_i kills stage 1; its RAM access (if any) is already on the pins.
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_nxt     = r_fill;
    w_stall_nxt    = 1'b0;
    w_ram_ce_nxt   = 1'b0;
    w_ram_we_nxt   = 4'h0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_d_nxt    = r_ram_d;
    w_s1_vld_nxt   = 1'b0;
    w_s1_err_nxt   = 1'b0;
    w_s1_rd_nxt    = 1'b0;
    w_ack_nxt      = r_s1_vld & ~r_s1_err & wb_cyc_i;
    w_err_nxt      = r_s1_vld & r_s1_err & wb_cyc_i;
    w_ack_rd_nxt   = r_s1_vld & ~r_s1_err & wb_cyc_i & r_s1_rd;
    case (r_state)
      ST_INIT: begin
        if (r_fill[ADDR_WIDTH]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stall_nxt    = 1'b1;
          w_ram_ce_nxt   = 1'b1;
          w_ram_we_nxt   = 4'hF;
          w_ram_addr_nxt = r_fill[ADDR_WIDTH-1:0];
          w_ram_d_nxt    = 32'h0;
          w_fill_nxt     = r_fill + FILL_ONE;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_s1_vld_nxt = 1'b1;
          w_s1_err_nxt = w_oor;
          w_s1_rd_nxt  = ~wb_we_i;
          if (!w_oor) begin
            w_ram_ce_nxt   = 1'b1;
            w_ram_we_nxt   = wb_we_i ? wb_sel_i : 4'h0;
            w_ram_addr_nxt = wb_adr_i[ADDR_WIDTH+1:2];
            w_ram_d_nxt    = wb_dat_i;
          end else begin
            w_ram_ce_nxt = 1'b0;
          end
        end else begin
          w_s1_vld_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = RST_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_fill     <= '0;
      r_stall    <= INIT_ZERO;
      r_ram_ce   <= 1'b0;
      r_ram_we   <= 4'h0;
      r_ram_addr <= '0;
      r_ram_d    <= 32'h0;
      r_s1_vld   <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_rd    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_ack_rd   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill     <= w_fill_nxt;
      r_stall    <= w_stall_nxt;
      r_ram_ce   <= w_ram_ce_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_d    <= w_ram_d_nxt;
      r_s1_vld   <= w_s1_vld_nxt;
      r_s1_err   <= w_s1_err_nxt;
      r_s1_rd    <= w_s1_rd_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_ack_rd   <= w_ack_rd_nxt;
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_stall_o = r_stall;
  assign wb_dat_o   = r_ack_rd ? ram_q : 32'h0;
  assign ram_ce     = r_ram_ce;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_d      = r_ram_d;

endmodule
